// File: rtl/led_scanner.sv
// Scan controller for an N-digit common-anode 7-seg display: per-slot dead-time blanking,
// frame-synchronous double-buffered display data and optional leading-zero suppression.
module led_scanner #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned DEAD       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dots,
  input  logic                      lz_blank,
  output logic [3:0]                dat_out,
  output logic                      dot_out,
  output logic                      en_out,
  output logic [NUM_DIGITS-1:0]     dig_n,
  output logic                      frame_tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] DeadCnt = CntW'(DEAD - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, stg_val_q, stg_val_d;
  logic [NUM_DIGITS-1:0]   act_dot_q, act_dot_d, stg_dot_q, stg_dot_d;
  logic                    pending_q, pending_d;
  logic [3:0]              dat_out_d;
  logic                    dot_out_d, en_out_d, frame_tick_d;
  logic [NUM_DIGITS-1:0]   dig_n_d;
  logic                    boundary, all_zero, supp;

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    state_d   = state_q;
    act_val_d = act_val_q;
    act_dot_d = act_dot_q;
    stg_val_d = stg_val_q;
    stg_dot_d = stg_dot_q;
    pending_d = pending_q;
    boundary  = (idx_q == LastIdx) && (cnt_q == LastCnt);

    if (cnt_q == LastCnt) begin
      cnt_d   = '0;
      state_d = StBlank;
      idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end else if (cnt_q == DeadCnt) begin
      state_d = StShow;
    end

    if (boundary && pending_q) begin
      act_val_d = stg_val_q;
      act_dot_d = stg_dot_q;
      pending_d = 1'b0;
    end

    // A load on the boundary cycle goes straight to the active buffer.
    if (load) begin
      if (boundary) begin
        act_val_d = value;
        act_dot_d = dots;
        pending_d = 1'b0;
      end else begin
        stg_val_d = value;
        stg_dot_d = dots;
        pending_d = 1'b1;
      end
    end
  end

  // Outputs are derived from next-state so they change on the same edge as the state.
  always_comb begin
    dat_out_d = 4'h0;
    all_zero  = 1'b1;
    supp      = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (IdxW'(i) == idx_d) dat_out_d = act_val_d[4*i +: 4];
    end
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      all_zero = all_zero & (act_val_d[4*i +: 4] == 4'h0);
      if (IdxW'(i) == idx_d) supp = all_zero;
    end
    dot_out_d    = act_dot_d[idx_d];
    en_out_d     = (state_d == StShow) && !(lz_blank && supp);
    frame_tick_d = boundary;
    dig_n_d      = '1;
    if (state_d == StShow) dig_n_d[idx_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBlank;
      cnt_q      <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dot_q  <= '0;
      stg_val_q  <= '0;
      stg_dot_q  <= '0;
      pending_q  <= 1'b0;
      dat_out    <= 4'h0;
      dot_out    <= 1'b0;
      en_out     <= 1'b0;
      dig_n      <= '1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dot_q  <= act_dot_d;
      stg_val_q  <= stg_val_d;
      stg_dot_q  <= stg_dot_d;
      pending_q  <= pending_d;
      dat_out    <= dat_out_d;
      dot_out    <= dot_out_d;
      en_out     <= en_out_d;
      dig_n      <= dig_n_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule
